// File: rtl/food_placement_controller.sv
// Food placement sequencer: samples random grid coordinates until an empty cell is found, then writes food there.
// Optional FOOD_PLACE_SCAN_EN adds a row-major fallback scan after MAX_TRIES random misses.
module food_placement_controller #(
   parameter int GRID_WIDTH     = 40,
   parameter int GRID_HEIGHT    = 30,
   parameter int BITS_PER_BLOCK = 2,
   parameter int BLOCK_EMPTY    = 0,
   parameter int BLOCK_FOOD     = 3,
   parameter int MAX_TRIES      = 16,
   parameter int HW             = $clog2(GRID_WIDTH),
   parameter int VW             = $clog2(GRID_HEIGHT),
   parameter int TW             = $clog2(MAX_TRIES + 1)
) (
   input  logic                      MasterClock,
   input  logic                      Reset,
   input  logic                      PlaceReq,
   input  logic [VW-1:0]             RandV,
   input  logic [HW-1:0]             RandH,
   output logic                      RdEn,
   output logic [VW-1:0]             RdV,
   output logic [HW-1:0]             RdH,
   input  logic [BITS_PER_BLOCK-1:0] RdData,
   output logic                      WrEn,
   output logic [VW-1:0]             WrV,
   output logic [HW-1:0]             WrH,
   output logic [BITS_PER_BLOCK-1:0] WrData,
   output logic                      Busy,
   output logic                      PlaceDone,
   output logic                      PlaceOk,
   output logic [VW-1:0]             FoodV,
   output logic [HW-1:0]             FoodH
);

   typedef enum logic [2:0] {
      IDLE, ISSUE, CHECK, WRITE, FAIL
`ifdef FOOD_PLACE_SCAN_EN
      , SCAN_ISSUE, SCAN_CHECK
`endif
   } state_t;

   state_t          state, state_n;
   logic [TW-1:0]   tries, tries_inc;
   logic [VW-1:0]   cand_v, red_v;
   logic [HW-1:0]   cand_h, red_h;
   logic            hit, last_try;

   // One conditional subtract is enough because 2^VW < 2*GRID_HEIGHT (same for H).
   assign red_v = (int'(RandV) >= GRID_HEIGHT) ? VW'(int'(RandV) - GRID_HEIGHT) : RandV;
   assign red_h = (int'(RandH) >= GRID_WIDTH)  ? HW'(int'(RandH) - GRID_WIDTH)  : RandH;

   assign hit       = (RdData == BITS_PER_BLOCK'(BLOCK_EMPTY));
   assign tries_inc = tries + TW'(1);
   assign last_try  = (tries_inc == TW'(MAX_TRIES));

`ifdef FOOD_PLACE_SCAN_EN
   logic [VW-1:0] scan_v;
   logic [HW-1:0] scan_h;
   logic          scan_last;
   assign scan_last = (scan_v == VW'(GRID_HEIGHT - 1)) && (scan_h == HW'(GRID_WIDTH - 1));
`endif

   always_ff @(posedge MasterClock or posedge Reset) begin
      if (Reset) begin
         state  <= IDLE;
         tries  <= '0;
         cand_v <= '0;
         cand_h <= '0;
         FoodV  <= '0;
         FoodH  <= '0;
`ifdef FOOD_PLACE_SCAN_EN
         scan_v <= '0;
         scan_h <= '0;
`endif
      end else begin
         state <= state_n;
         case (state)
            IDLE:  if (PlaceReq) tries <= '0;
            ISSUE: begin
               cand_v <= red_v;
               cand_h <= red_h;
            end
            CHECK: if (!hit) begin
               tries <= tries_inc;
`ifdef FOOD_PLACE_SCAN_EN
               scan_v <= '0;
               scan_h <= '0;
`endif
            end
            WRITE: begin
               FoodV <= cand_v;
               FoodH <= cand_h;
            end
`ifdef FOOD_PLACE_SCAN_EN
            SCAN_ISSUE: begin
               cand_v <= scan_v;
               cand_h <= scan_h;
            end
            SCAN_CHECK: if (!hit && !scan_last) begin
               if (scan_h == HW'(GRID_WIDTH - 1)) begin
                  scan_h <= '0;
                  scan_v <= scan_v + VW'(1);
               end else begin
                  scan_h <= scan_h + HW'(1);
               end
            end
`endif
            default: ;
         endcase
      end
   end

   always_comb begin
      state_n   = state;
      RdEn      = 1'b0;
      RdV       = '0;
      RdH       = '0;
      WrEn      = 1'b0;
      WrV       = '0;
      WrH       = '0;
      WrData    = '0;
      PlaceDone = 1'b0;
      PlaceOk   = 1'b0;
      Busy      = (state != IDLE);
      case (state)
         IDLE:  if (PlaceReq) state_n = ISSUE;
         ISSUE: begin
            RdEn    = 1'b1;
            RdV     = red_v;
            RdH     = red_h;
            state_n = CHECK;
         end
         CHECK: begin
            if (hit)           state_n = WRITE;
`ifdef FOOD_PLACE_SCAN_EN
            else if (last_try) state_n = SCAN_ISSUE;
`else
            else if (last_try) state_n = FAIL;
`endif
            else               state_n = ISSUE;
         end
         WRITE: begin
            WrEn      = 1'b1;
            WrV       = cand_v;
            WrH       = cand_h;
            WrData    = BITS_PER_BLOCK'(BLOCK_FOOD);
            PlaceDone = 1'b1;
            PlaceOk   = 1'b1;
            state_n   = IDLE;
         end
         FAIL: begin
            PlaceDone = 1'b1;
            state_n   = IDLE;
         end
`ifdef FOOD_PLACE_SCAN_EN
         SCAN_ISSUE: begin
            RdEn    = 1'b1;
            RdV     = scan_v;
            RdH     = scan_h;
            state_n = SCAN_CHECK;
         end
         SCAN_CHECK: begin
            if (hit)            state_n = WRITE;
            else if (scan_last) state_n = FAIL;
            else                state_n = SCAN_ISSUE;
         end
`endif
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_food_placement_controller.sv
// Directed bench for food_placement_controller with a registered-read grid model and protocol monitor.
module tb_food_placement_controller;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       place_req = 1'b0;
   logic [4:0] rand_v, rv_drv = '0;
   logic [5:0] rand_h, rh_drv = '0;
   logic       rd_en, wr_en, busy, place_done, place_ok;
   logic [4:0] rd_v, wr_v, food_v;
   logic [5:0] rd_h, wr_h, food_h;
   logic [1:0] rd_data = '0, wr_data;

   logic [1:0] grid [0:29][0:39];

   int passed = 0, total = 0;
   int rd_issued = 0, wr_cnt = 0, done_cnt = 0, viol = 0;
   int seq_base = 0, seq_off;
   bit seq_en = 1'b0;
   int seq_v [3], seq_h [3];

   food_placement_controller dut (
      .MasterClock(clk), .Reset(rst), .PlaceReq(place_req),
      .RandV(rand_v), .RandH(rand_h),
      .RdEn(rd_en), .RdV(rd_v), .RdH(rd_h), .RdData(rd_data),
      .WrEn(wr_en), .WrV(wr_v), .WrH(wr_h), .WrData(wr_data),
      .Busy(busy), .PlaceDone(place_done), .PlaceOk(place_ok),
      .FoodV(food_v), .FoodH(food_h)
   );

   always #5 clk = ~clk;

   // Random source: either a fixed value or a per-read sequence.
   assign seq_off = (rd_issued - seq_base > 2) ? 2 : rd_issued - seq_base;
   assign rand_v  = seq_en ? 5'(seq_v[seq_off]) : rv_drv;
   assign rand_h  = seq_en ? 6'(seq_h[seq_off]) : rh_drv;

   always @(posedge clk) begin
      if (rd_en) begin
         rd_data   <= grid[rd_v][rd_h];
         rd_issued <= rd_issued + 1;
      end
   end

   always @(negedge clk) begin
      done_cnt <= done_cnt + int'(place_done);
      wr_cnt   <= wr_cnt + int'(wr_en);
      viol     <= viol + int'(rd_en && wr_en) + int'(place_ok && !place_done)
                + int'(rd_en && (rd_v >= 5'd30 || rd_h >= 6'd40))
                + int'(wr_en && (wr_v >= 5'd30 || wr_h >= 6'd40))
                + int'(!rd_en && (rd_v != '0 || rd_h != '0))
                + int'(!wr_en && (wr_v != '0 || wr_h != '0 || wr_data != '0))
                + int'(wr_en && wr_data != 2'd3);
   end

   typedef struct { int rv; int rh; int ev; int eh; } vec_t;
   vec_t vecs [6];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_grid(input logic [1:0] val);
      for (int v = 0; v < 30; v++)
         for (int h = 0; h < 40; h++)
            grid[v][h] = val;
   endtask

   task automatic run_single(input int rv, input int rh, input int ev, input int eh);
      rv_drv = 5'(rv);
      rh_drv = 6'(rh);
      tick();
      place_req = 1'b1;
      tick();
      place_req = 1'b0;
      chk("issue_rden", int'(rd_en), 1);
      chk("issue_rdv", int'(rd_v), ev);
      chk("issue_rdh", int'(rd_h), eh);
      chk("issue_busy", int'(busy), 1);
      tick();
      chk("check_rden", int'(rd_en), 0);
      tick();
      chk("write_wren", int'(wr_en), 1);
      chk("write_addr", int'(wr_v) * 64 + int'(wr_h), ev * 64 + eh);
      chk("write_data", int'(wr_data), 3);
      chk("write_done_ok", int'({place_done, place_ok}), 3);
      tick();
      chk("idle_busy", int'(busy), 0);
      chk("idle_done", int'(place_done), 0);
      chk("food_pos", int'(food_v) * 64 + int'(food_h), ev * 64 + eh);
   endtask

   initial begin
      int cyc, rd0, wr0, dn0, exp_cyc;
      vecs[0] = '{5, 7, 5, 7};
      vecs[1] = '{31, 45, 1, 5};
      vecs[2] = '{0, 0, 0, 0};
      vecs[3] = '{29, 39, 29, 39};
      vecs[4] = '{30, 40, 0, 0};
      vecs[5] = '{31, 63, 1, 23};
      fill_grid(2'd0);

      tick();
      tick();
      chk("reset_busy", int'(busy), 0);
      chk("reset_outs", int'({rd_en, wr_en, place_done, place_ok}), 0);
      chk("reset_food", int'(food_v) + int'(food_h), 0);
      rst = 1'b0;

      foreach (vecs[i]) run_single(vecs[i].rv, vecs[i].rh, vecs[i].ev, vecs[i].eh);

      // Two occupied candidates, then an empty one.
      grid[2][2] = 2'd1;
      grid[3][3] = 2'd1;
      seq_v = '{2, 3, 4};
      seq_h = '{2, 3, 4};
      tick();
      seq_base = rd_issued;
      seq_en = 1'b1;
      rd0 = rd_issued;
      wr0 = wr_cnt;
      place_req = 1'b1;
      tick();
      place_req = 1'b0;
      cyc = 1;
      while (!place_done && cyc < 50) begin
         tick();
         cyc++;
      end
      chk("retry_done_cycle", cyc, 7);
      chk("retry_addr", int'(wr_v) * 64 + int'(wr_h), 4 * 64 + 4);
      tick();
      chk("retry_reads", rd_issued - rd0, 3);
      chk("retry_writes", wr_cnt - wr0, 1);
      chk("retry_food", int'(food_v) * 64 + int'(food_h), 4 * 64 + 4);
      seq_en = 1'b0;

      // Full grid except the last cell; random always lands on occupied cells.
      fill_grid(2'd1);
      grid[29][39] = 2'd0;
      rv_drv = 5'd5;
      rh_drv = 6'd7;
      rd0 = rd_issued;
      wr0 = wr_cnt;
      place_req = 1'b1;
      tick();
      place_req = 1'b0;
      cyc = 1;
      while (!place_done && cyc < 4000) begin
         tick();
         cyc++;
      end
`ifdef FOOD_PLACE_SCAN_EN
      exp_cyc = 2433;
      chk("full_ok", int'(place_ok), 1);
      chk("full_wr_addr", int'(wr_v) * 64 + int'(wr_h), 29 * 64 + 39);
      tick();
      chk("full_reads", rd_issued - rd0, 1216);
      chk("full_writes", wr_cnt - wr0, 1);
`else
      exp_cyc = 33;
      chk("full_ok", int'(place_ok), 0);
      chk("full_wren", int'(wr_en), 0);
      tick();
      chk("full_reads", rd_issued - rd0, 16);
      chk("full_writes", wr_cnt - wr0, 0);
`endif
      chk("full_done_cycle", cyc, exp_cyc);

      // Reset while re-issuing after a miss.
      fill_grid(2'd0);
      grid[5][7] = 2'd1;
      tick();
      place_req = 1'b1;
      tick();
      place_req = 1'b0;
      tick();
      tick();
      chk("pre_reset_rden", int'(rd_en), 1);
      wr0 = wr_cnt;
      dn0 = done_cnt;
      rst = 1'b1;
      #1;
      chk("async_reset_busy", int'(busy), 0);
      chk("async_reset_rden", int'(rd_en), 0);
      tick();
      tick();
      rst = 1'b0;
      repeat (3) tick();
      chk("reset_no_write", wr_cnt - wr0, 0);
      chk("reset_no_done", done_cnt - dn0, 0);
      grid[5][7] = 2'd0;
      run_single(5, 7, 5, 7);

      // Held request: back-to-back placements every 4 cycles.
      rv_drv = 5'd3;
      rh_drv = 6'd4;
      dn0 = done_cnt;
      wr0 = wr_cnt;
      place_req = 1'b1;
      repeat (20) tick();
      place_req = 1'b0;
      chk("b2b_dones", done_cnt - dn0, 5);
      chk("b2b_writes", wr_cnt - wr0, 5);

      // Toggling the request while busy is ignored.
      tick();
      dn0 = done_cnt;
      place_req = 1'b1;
      tick();
      place_req = 1'b0;
      tick();
      place_req = 1'b1;
      tick();
      tick();
      place_req = 1'b0;
      repeat (6) tick();
      chk("toggle_dones", done_cnt - dn0, 1);
      chk("toggle_idle", int'(busy), 0);

      chk("protocol_violations", viol, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
